// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count/width, debounce default and status bit encoding.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 4;
  localparam int DEB_TICKS  = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  // Status vector bit order used by the state machine.
  typedef enum logic [1:0] {
    STAT_UP    = 2'd0,
    STAT_DOWN  = 2'd1,
    STAT_OPEN  = 2'd2,
    STAT_CLOSE = 2'd3
  } status_bit_e;

  // Which hall call directions a door-open service clears: {down_en, up_en}.
  // An idle car (neither direction) serves both.
  function automatic logic [1:0] dir_clear_mask(input logic dir_up, input logic dir_down);
    logic [1:0] mask;
    mask[0] = dir_up | ~dir_down;
    mask[1] = dir_down | ~dir_up;
    return mask;
  endfunction

endpackage

// File: rtl/call_debouncer.sv
// One raw input: 2-flop synchroniser, tick-driven debounce counter, stable level and a registered rise pulse.
module call_debouncer #(
  parameter int DEB_TICKS = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEB_TICKS > 2) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_TICKS - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             stable;

  // Synchronise, then accept a new level only after DEB_TICKS consecutive differing tick samples.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync   <= 2'b00;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (tick) begin
        if (sync[1] != stable) begin
          if (cnt == LAST) begin
            stable <= sync[1];
            cnt    <= '0;
            rise   <= sync[1];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule

// File: rtl/call_request_latch.sv
// Debounces car/hall inputs and latches up/down/car call vectors, cleared when the car is serviced at a floor.
// Optional build macro CALL_CANCEL_EN: a fresh press on an already latched call cancels it.
module call_request_latch #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int DEB_TICKS  = elevator_pkg::DEB_TICKS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] car_sw,
  input  logic [2:0]            hall_sel,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  door_open,
  input  logic                  dir_up,
  input  logic                  dir_down,
  output logic [NUM_FLOORS-1:0] up_call,
  output logic [NUM_FLOORS-1:0] down_call,
  output logic [NUM_FLOORS-1:0] car_call,
  output logic                  new_call
);

  import elevator_pkg::*;

  logic [2:0]            hall_meta;
  logic [2:0]            hall_sync;
  logic [NUM_FLOORS-1:0] car_rise;
  logic                  up_rise;
  logic                  down_rise;

  logic [1:0]            dir_clr;
  logic [NUM_FLOORS-1:0] up_set, down_set, car_set;
  logic [NUM_FLOORS-1:0] up_clr, down_clr, car_clr;
  logic [NUM_FLOORS-1:0] up_nxt, down_nxt, car_nxt;
  logic                  new_nxt;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_car
    call_debouncer #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .raw  (car_sw[i]),
      .rise (car_rise[i])
    );
  end

  call_debouncer #(.DEB_TICKS(DEB_TICKS)) u_deb_up (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick),
    .raw  (btn_up),
    .rise (up_rise)
  );

  call_debouncer #(.DEB_TICKS(DEB_TICKS)) u_deb_down (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick),
    .raw  (btn_down),
    .rise (down_rise)
  );

  // Hall floor select is only synchronised; it is consumed at the debounced button edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hall_meta <= 3'd0;
      hall_sync <= 3'd0;
    end else begin
      hall_meta <= hall_sel;
      hall_sync <= hall_meta;
    end
  end

  // Set/clear decode; a clear on the same bit always beats a set or cancel.
  always_comb begin
    dir_clr  = dir_clear_mask(dir_up, dir_down);
    up_set   = '0;
    down_set = '0;
    car_set  = car_rise;
    up_clr   = '0;
    down_clr = '0;
    car_clr  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      up_set[i]   = up_rise   & (int'(hall_sync) == i) & (i != NUM_FLOORS - 1);
      down_set[i] = down_rise & (int'(hall_sync) == i) & (i != 0);
      car_clr[i]  = door_open & (int'(cur_floor) == i);
      up_clr[i]   = car_clr[i] & dir_clr[0];
      down_clr[i] = car_clr[i] & dir_clr[1];
    end
`ifdef CALL_CANCEL_EN
    up_nxt   = (up_call   ^ up_set)   & ~up_clr;
    down_nxt = (down_call ^ down_set) & ~down_clr;
    car_nxt  = (car_call  ^ car_set)  & ~car_clr;
`else
    up_nxt   = (up_call   | up_set)   & ~up_clr;
    down_nxt = (down_call | down_set) & ~down_clr;
    car_nxt  = (car_call  | car_set)  & ~car_clr;
`endif
    new_nxt = |((up_set   & ~up_call   & ~up_clr) |
                (down_set & ~down_call & ~down_clr) |
                (car_set  & ~car_call  & ~car_clr));
  end

  // Call vectors and the new-call pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      up_call   <= '0;
      down_call <= '0;
      car_call  <= '0;
      new_call  <= 1'b0;
    end else begin
      up_call   <= up_nxt;
      down_call <= down_nxt;
      car_call  <= car_nxt;
      new_call  <= new_nxt;
    end
  end

endmodule

// File: tb/tb_call_request_latch.sv
// Scoreboard bench for call_request_latch: expected call vectors are queued with the stimulus and popped at check points.
module tb_call_request_latch;

  logic       CLK;
  logic       RST;
  logic       tick;
  logic [7:0] car_sw;
  logic [2:0] hall_sel;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] cur_floor;
  logic       door_open;
  logic       dir_up;
  logic       dir_down;
  logic [7:0] up_call;
  logic [7:0] down_call;
  logic [7:0] car_call;
  logic       new_call;

  typedef struct {
    string      tag;
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] car;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   pulse_cnt = 0;
  int   p0;

  call_request_latch dut (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (tick),
    .car_sw    (car_sw),
    .hall_sel  (hall_sel),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .cur_floor (cur_floor),
    .door_open (door_open),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .up_call   (up_call),
    .down_call (down_call),
    .car_call  (car_call),
    .new_call  (new_call)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (new_call === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] up, input logic [7:0] down, input logic [7:0] car);
    exp_t e;
    e.tag  = tag;
    e.up   = up;
    e.down = down;
    e.car  = car;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_up"},   {24'd0, up_call},   {24'd0, e.up});
      check({e.tag, "_down"}, {24'd0, down_call}, {24'd0, e.down});
      check({e.tag, "_car"},  {24'd0, car_call},  {24'd0, e.car});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Each tick is preceded by an idle cycle; returns just after the tick edge.
  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b0;
      @(negedge CLK);
      tick = 1'b1;
      @(negedge CLK);
    end
    tick = 1'b0;
  endtask

  // kind: 0 car switch idx, 1 hall up at idx, 2 hall down at idx
  task automatic press(input int kind, input int idx);
    if (kind == 0) car_sw[idx] = 1'b1;
    else if (kind == 1) begin hall_sel = 3'(idx); btn_up = 1'b1; end
    else begin hall_sel = 3'(idx); btn_down = 1'b1; end
    cyc(2);
    tick_n(4);
    cyc(1);
  endtask

  task automatic release_in(input int kind, input int idx);
    if (kind == 0) car_sw[idx] = 1'b0;
    else if (kind == 1) btn_up = 1'b0;
    else btn_down = 1'b0;
    cyc(2);
    tick_n(5);
  endtask

  initial begin
    RST = 1'b0; tick = 1'b0; car_sw = 8'h00; hall_sel = 3'd0; btn_up = 1'b0; btn_down = 1'b0;
    cur_floor = 4'd0; door_open = 1'b0; dir_up = 1'b0; dir_down = 1'b0;
    cyc(3);
    push_exp("reset", 8'h00, 8'h00, 8'h00); check_sb();
    check("reset_new", {31'd0, new_call}, 32'd0);
    RST = 1'b1;
    cyc(2);

    // Car call latency: nothing at the debounce edge, set one clock later.
    p0 = pulse_cnt;
    car_sw[5] = 1'b1;
    cyc(2);
    tick_n(4);
    push_exp("t1_pre", 8'h00, 8'h00, 8'h00); check_sb();
    cyc(1);
    push_exp("t1_set", 8'h00, 8'h00, 8'h20); check_sb();
    check("t1_pulse_hi", {31'd0, new_call}, 32'd1);
    cyc(1);
    check("t1_pulse_lo", {31'd0, new_call}, 32'd0);
    tick_n(2);
    push_exp("t1_held", 8'h00, 8'h00, 8'h20); check_sb();
    release_in(0, 5);
    check("t1_pulses", 32'(pulse_cnt - p0), 32'd1);
    cur_floor = 4'd5; door_open = 1'b1;
    cyc(1);
    push_exp("t1_serve", 8'h00, 8'h00, 8'h00); check_sb();
    door_open = 1'b0;

    // Glitch shorter than the debounce window.
    p0 = pulse_cnt;
    car_sw[3] = 1'b1;
    cyc(2);
    tick_n(2);
    car_sw[3] = 1'b0;
    cyc(2);
    tick_n(6);
    cyc(2);
    push_exp("t2_glitch", 8'h00, 8'h00, 8'h00); check_sb();
    check("t2_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Hall up call and direction-qualified service.
    press(1, 2);
    push_exp("t3_up2", 8'h04, 8'h00, 8'h00); check_sb();
    release_in(1, 2);
    cur_floor = 4'd2; door_open = 1'b1; dir_down = 1'b1; dir_up = 1'b0;
    cyc(1);
    push_exp("t3_wrong_dir", 8'h04, 8'h00, 8'h00); check_sb();
    dir_up = 1'b1; dir_down = 1'b0;
    cyc(1);
    push_exp("t3_serve", 8'h00, 8'h00, 8'h00); check_sb();
    door_open = 1'b0; dir_up = 1'b0;

    // Nonexistent hall buttons, then the valid extreme ones.
    p0 = pulse_cnt;
    press(1, 7); release_in(1, 7);
    press(2, 0); release_in(2, 0);
    push_exp("t4_bound", 8'h00, 8'h00, 8'h00); check_sb();
    check("t4_pulses_none", 32'(pulse_cnt - p0), 32'd0);
    p0 = pulse_cnt;
    press(1, 0); release_in(1, 0);
    press(2, 7); release_in(2, 7);
    push_exp("t4_edges", 8'h01, 8'h80, 8'h00); check_sb();
    check("t4_pulses_two", 32'(pulse_cnt - p0), 32'd2);
    cur_floor = 4'd8; door_open = 1'b1;
    cyc(1);
    push_exp("t4_floor_oor", 8'h01, 8'h80, 8'h00); check_sb();
    cur_floor = 4'd0;
    cyc(1);
    push_exp("t4_idle_serve", 8'h00, 8'h80, 8'h00); check_sb();
    cur_floor = 4'd7; dir_up = 1'b1;
    cyc(1);
    push_exp("t4_up_keeps_down", 8'h00, 8'h80, 8'h00); check_sb();
    dir_up = 1'b0; dir_down = 1'b1;
    cyc(1);
    push_exp("t4_down_serve", 8'h00, 8'h00, 8'h00); check_sb();
    door_open = 1'b0; dir_down = 1'b0;

    // Set and service on the same edge: clear wins, no pulse, no retry.
    p0 = pulse_cnt;
    car_sw[4] = 1'b1;
    cyc(2);
    tick_n(4);
    cur_floor = 4'd4; door_open = 1'b1;
    cyc(1);
    push_exp("t5_collide", 8'h00, 8'h00, 8'h00); check_sb();
    door_open = 1'b0;
    cyc(2);
    check("t5_pulses", 32'(pulse_cnt - p0), 32'd0);
    release_in(0, 4);
    push_exp("t5_no_retry", 8'h00, 8'h00, 8'h00); check_sb();

    // Second press on a latched call.
    p0 = pulse_cnt;
    press(0, 1);
    push_exp("t5_first", 8'h00, 8'h00, 8'h02); check_sb();
    release_in(0, 1);
    press(0, 1);
`ifdef CALL_CANCEL_EN
    push_exp("t5_cancel", 8'h00, 8'h00, 8'h00); check_sb();
`else
    push_exp("t5_repress", 8'h00, 8'h00, 8'h02); check_sb();
`endif
    release_in(0, 1);
    check("t5_repress_pulses", 32'(pulse_cnt - p0), 32'd1);
    cur_floor = 4'd1; door_open = 1'b1;
    cyc(1);
    door_open = 1'b0;
    push_exp("t5_clean", 8'h00, 8'h00, 8'h00); check_sb();

    // Async reset mid-debounce with pending calls; held input re-debounced afterwards.
    press(1, 0); release_in(1, 0);
    press(1, 4); release_in(1, 4);
    push_exp("t6_pre", 8'h11, 8'h00, 8'h00); check_sb();
    hall_sel = 3'd3; btn_down = 1'b1;
    cyc(2);
    tick_n(2);
    #2 RST = 1'b0;
    #1;
    push_exp("t6_async", 8'h00, 8'h00, 8'h00); check_sb();
    check("t6_async_new", {31'd0, new_call}, 32'd0);
    @(negedge CLK);
    cyc(2);
    RST = 1'b1;
    p0 = pulse_cnt;
    cyc(2);
    tick_n(3);
    push_exp("t6_mid", 8'h00, 8'h00, 8'h00); check_sb();
    tick_n(1);
    push_exp("t6_pre_set", 8'h00, 8'h00, 8'h00); check_sb();
    cyc(1);
    push_exp("t6_set", 8'h00, 8'h08, 8'h00); check_sb();
    tick_n(4);
    push_exp("t6_hold", 8'h00, 8'h08, 8'h00); check_sb();
    check("t6_pulses", 32'(pulse_cnt - p0), 32'd1);
    btn_down = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
